// File: rtl/sparceMemPkg.sv
// Definitions shared by the sparse memory and its request adapter:
// op codes on the memory pins, adapter FSM states and size helpers.
package sparceMemPkg;

  localparam int BC     = 8;
  localparam int BADDR  = $clog2(BC);
  localparam int DATA_W = BC * 8;

  // Encoding is shared with the memory's we/re pins; NOP means no access.
  typedef enum logic [2:0] {
    NOP      = 3'd0,
    BYTE_OP  = 3'd1,
    HALF_OP  = 3'd2,
    WORD_OP  = 3'd3,
    DWORD_OP = 3'd4
  } op_size_e;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    RESP
  } adapter_state_e;

  // req_size carries log2(bytes), so the memory op code is that value plus one.
  function automatic op_size_e req_to_op(input logic [1:0] sz);
    return op_size_e'({1'b0, sz} + 3'd1);
  endfunction

  function automatic int size_bytes(input op_size_e op);
    case (op)
      BYTE_OP:  return 1;
      HALF_OP:  return 2;
      WORD_OP:  return 4;
      DWORD_OP: return 8;
      default:  return 0;
    endcase
  endfunction

  function automatic logic is_aligned(input logic [2:0] addr_lsb, input op_size_e op);
    case (op)
      BYTE_OP:  return 1'b1;
      HALF_OP:  return addr_lsb[0] == 1'b0;
      WORD_OP:  return addr_lsb[1:0] == 2'b00;
      DWORD_OP: return addr_lsb == 3'b000;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/sparce_mem_lane_align.sv
// Byte-lane steering between right-justified request data and memory lanes:
// shift-left for stores, shift-right / mask / extend for loads.
module sparce_mem_lane_align
  import sparceMemPkg::*;
(
  input  logic [DATA_W-1:0] i_st_wdata,
  input  logic [BADDR-1:0]  i_st_lane,
  output logic [DATA_W-1:0] o_st_lanes,
  input  logic [DATA_W-1:0] i_ld_lanes,
  input  logic [BADDR-1:0]  i_ld_lane,
  input  op_size_e          i_ld_op,
  input  logic              i_ld_signed,
  output logic [DATA_W-1:0] o_ld_data
);

  logic [DATA_W-1:0] w_ld_shifted;
  logic [DATA_W-1:0] w_ld_mask;
  logic              w_ld_sign;

  assign o_st_lanes   = i_st_wdata << {i_st_lane, 3'b000};
  assign w_ld_shifted = i_ld_lanes >> {i_ld_lane, 3'b000};

  always_comb begin
    w_ld_mask = '0;
    w_ld_sign = 1'b0;
    case (i_ld_op)
      BYTE_OP: begin
        w_ld_mask = DATA_W'(8'hFF);
        w_ld_sign = w_ld_shifted[7];
      end
      HALF_OP: begin
        w_ld_mask = DATA_W'(16'hFFFF);
        w_ld_sign = w_ld_shifted[15];
      end
      WORD_OP: begin
        w_ld_mask = DATA_W'(32'hFFFF_FFFF);
        w_ld_sign = w_ld_shifted[31];
      end
      DWORD_OP: begin
        w_ld_mask = '1;
        w_ld_sign = w_ld_shifted[DATA_W-1];
      end
      default: ;
    endcase
    o_ld_data = w_ld_shifted & w_ld_mask;
    if (i_ld_signed && w_ld_sign) begin
      o_ld_data = o_ld_data | ~w_ld_mask;
    end
  end

endmodule

// File: rtl/sparce_mem_req_adapter.sv
// Single-outstanding load/store front-end for the sparse memory: validates the
// request, pulses the memory pins for one cycle and returns a registered response.
module sparce_mem_req_adapter
  import sparceMemPkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              cs,
  output logic [2:0]        we,
  output logic [2:0]        re,
  output logic [ADDR_W-1:0] write_address,
  output logic [ADDR_W-1:0] read_address,
  output logic [DATA_W-1:0] write_data,
  input  logic [DATA_W-1:0] read_data
);

  adapter_state_e    r_state;
  adapter_state_e    w_state_next;
  logic [BADDR-1:0]  r_lane;
  op_size_e          r_op;
  logic              r_we;
  logic              r_signed;

  op_size_e          w_op;
  logic              w_legal;
  logic [DATA_W-1:0] w_st_lanes;
  logic [DATA_W-1:0] w_ld_data;

  assign w_op      = req_to_op(req_size);
  assign w_legal   = (size_bytes(w_op) != 0) && (size_bytes(w_op) <= BC) &&
                     is_aligned(req_addr[2:0], w_op);
  assign req_ready = (r_state == IDLE);

  sparce_mem_lane_align u_lane_align (
    .i_st_wdata  (req_wdata),
    .i_st_lane   (req_addr[BADDR-1:0]),
    .o_st_lanes  (w_st_lanes),
    .i_ld_lanes  (read_data),
    .i_ld_lane   (r_lane),
    .i_ld_op     (r_op),
    .i_ld_signed (r_signed),
    .o_ld_data   (w_ld_data)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (req_valid) w_state_next = w_legal ? ISSUE : RESP;
      ISSUE:   w_state_next = r_we ? RESP : CAPTURE;
      CAPTURE: w_state_next = RESP;
      RESP:    if (rsp_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Pin and response registers are loaded on the edge that enters the state they belong to.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state       <= IDLE;
      r_lane        <= '0;
      r_op          <= NOP;
      r_we          <= 1'b0;
      r_signed      <= 1'b0;
      cs            <= 1'b0;
      we            <= NOP;
      re            <= NOP;
      write_address <= '0;
      read_address  <= '0;
      write_data    <= '0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_err       <= 1'b0;
    end else begin
      r_state <= w_state_next;
      cs      <= 1'b0;
      we      <= NOP;
      re      <= NOP;
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_lane   <= req_addr[BADDR-1:0];
            r_op     <= w_op;
            r_we     <= req_we;
            r_signed <= req_signed;
            if (w_legal) begin
              cs <= 1'b1;
              if (req_we) begin
                we            <= w_op;
                write_address <= req_addr;
                write_data    <= w_st_lanes;
              end else begin
                re           <= w_op;
                read_address <= req_addr;
              end
            end else begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end
          end
        end
        ISSUE: begin
          if (r_we) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
          end
        end
        CAPTURE: begin
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_rdata <= w_ld_data;
        end
        RESP: begin
          if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sparce_mem_req_adapter.sv
// Directed bench for sparce_mem_req_adapter: a byte-array memory responder on the
// pins, a transaction-level reference model and a per-cycle output compare.
module tb_sparce_mem_req_adapter;
  import sparceMemPkg::*;

  localparam int AW = 32;
  localparam int DW = DATA_W;

  logic          clk = 1'b0;
  logic          nrst = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_we = 1'b0;
  logic [1:0]    req_size = 2'd0;
  logic          req_signed = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_ready = 1'b1;
  logic [DW-1:0] read_data = '0;
  logic          req_ready, rsp_valid, rsp_err, cs;
  logic [DW-1:0] rsp_rdata, write_data;
  logic [2:0]    we, re;
  logic [AW-1:0] write_address, read_address;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sparce_mem_req_adapter #(.ADDR_W(AW)) dut (
    .clk(clk), .nrst(nrst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .cs(cs), .we(we), .re(re),
    .write_address(write_address), .read_address(read_address),
    .write_data(write_data), .read_data(read_data)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out, required event never seen (t=%0t)", name, $time);
  endtask

  // Reference model: byte-addressed memory plus expected per-cycle outputs.
  logic [7:0]  ref_mem [int unsigned];
  logic [7:0]  phy_mem [int unsigned];
  bit          m_busy = 1'b0;
  int          m_cnt = 0;
  bit          e_rsp_valid = 1'b0;
  bit          e_rsp_err = 1'b0;
  logic [63:0] e_rsp_rdata = '0;
  bit          e_cs = 1'b0;
  logic [2:0]  e_we = '0;
  logic [2:0]  e_re = '0;
  logic [31:0] e_wa = '0;
  logic [31:0] e_ra = '0;
  logic [63:0] e_wd = '0;

  function automatic logic [7:0] ref_rd(input int unsigned a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

  function automatic logic [7:0] phy_rd(input int unsigned a);
    return phy_mem.exists(a) ? phy_mem[a] : 8'h00;
  endfunction

  task automatic model_accept();
    int          n;
    int unsigned a;
    bit          legal;
    logic [63:0] v;
    n     = 1 << req_size;
    a     = req_addr;
    legal = ((a % n) == 0) && (n <= BC);
    v     = '0;
    m_busy = 1'b1;
    if (!legal) begin
      m_cnt       = 0;
      e_rsp_valid = 1'b1;
      e_rsp_err   = 1'b1;
      e_rsp_rdata = '0;
    end else if (req_we) begin
      m_cnt       = 1;
      e_rsp_err   = 1'b0;
      e_rsp_rdata = '0;
      for (int i = 0; i < n; i++) ref_mem[a + i] = req_wdata[8*i +: 8];
      e_cs = 1'b1;
      e_we = 3'(req_size) + 3'd1;
      e_wa = a;
      e_wd = req_wdata << (8 * (a % BC));
    end else begin
      m_cnt = 2;
      for (int i = 0; i < n; i++) v[8*i +: 8] = ref_rd(a + i);
      if (req_signed && v[8*n-1]) v = v | ~((64'h1 << (8 * n)) - 64'h1);
      e_rsp_err   = 1'b0;
      e_rsp_rdata = v;
      e_cs = 1'b1;
      e_re = 3'(req_size) + 3'd1;
      e_ra = a;
    end
  endtask

  initial forever begin
    bit was_idle;
    @(posedge clk);
    if (!nrst) begin
      m_busy = 1'b0;
      m_cnt = 0;
      e_rsp_valid = 1'b0;
      e_cs = 1'b0;
      e_we = '0;
      e_re = '0;
    end else begin
      was_idle = !m_busy;
      e_cs = 1'b0;
      e_we = '0;
      e_re = '0;
      if (m_busy) begin
        if (m_cnt > 0) begin
          m_cnt--;
          if (m_cnt == 0) e_rsp_valid = 1'b1;
        end else if (rsp_ready) begin
          e_rsp_valid = 1'b0;
          m_busy = 1'b0;
        end
      end
      if (was_idle && req_valid) model_accept();
    end
  end

  // Per-cycle compare against the model.
  initial forever begin
    @(negedge clk);
    if (nrst) begin
      chk("req_ready", 64'(req_ready), 64'(!m_busy));
      chk("rsp_valid", 64'(rsp_valid), 64'(e_rsp_valid));
      if (e_rsp_valid) begin
        chk("rsp_rdata", rsp_rdata, e_rsp_rdata);
        chk("rsp_err", 64'(rsp_err), 64'(e_rsp_err));
      end
      chk("cs", 64'(cs), 64'(e_cs));
      chk("we", 64'(we), 64'(e_we));
      chk("re", 64'(re), 64'(e_re));
      if (e_cs && e_we != 3'd0) begin
        chk("write_address", 64'(write_address), 64'(e_wa));
        chk("write_data", write_data, e_wd);
      end
      if (e_cs && e_re != 3'd0) chk("read_address", 64'(read_address), 64'(e_ra));
    end
  end

  // Memory responder: applies pin writes and returns the addressed line one cycle after a read.
  initial forever begin
    bit          pend;
    int          n;
    int          lane;
    int unsigned base;
    logic [63:0] pline;
    @(negedge clk);
    pend = 1'b0;
    pline = '0;
    if (nrst && cs) begin
      if (we != 3'd0) begin
        n    = (we <= 3'd4) ? (1 << (int'(we) - 1)) : 0;
        lane = int'(write_address % BC);
        for (int i = 0; i < n; i++)
          if (lane + i < BC) phy_mem[write_address + i] = write_data[8*(lane+i) +: 8];
      end
      if (re != 3'd0) begin
        pend = 1'b1;
        base = read_address & ~(BC - 1);
        for (int k = 0; k < BC; k++) pline[8*k +: 8] = phy_rd(base + k);
      end
    end
    @(posedge clk);
    #1;
    read_data = pend ? pline : 64'hA5A5_5A5A_A5A5_5A5A;
  end

  int          acc_cyc, hs_cyc, lat, prev_acc;
  logic [63:0] got_rdata;
  logic        got_err;
  logic        iss_cs;
  logic [2:0]  iss_we, iss_re;
  logic [63:0] iss_wd;
  logic [31:0] iss_wa, iss_ra;

  // Called at posedge+1; returns at posedge+1 of the accept edge (first cycle after accept).
  task automatic issue(input bit w, input logic [1:0] sz, input bit sg,
                       input logic [31:0] a, input logic [63:0] d, input bit keep);
    bit ok;
    req_valid = 1'b1; req_we = w; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = d;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    if (!ok) timeout_fail("accept");
    acc_cyc = cyc;
    if (!keep) req_valid = 1'b0;
    iss_cs = cs; iss_we = we; iss_re = re;
    iss_wd = write_data; iss_wa = write_address; iss_ra = read_address;
    $display("req  we=%0d size=%0d signed=%0d addr=0x%0h wdata=0x%0h accepted at cycle %0d",
             w, sz, sg, a, d, acc_cyc);
  endtask

  task automatic wait_rsp(input int stall);
    bit seen;
    seen = 1'b0;
    lat = 0;
    if (stall > 0) rsp_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      timeout_fail("rsp_valid");
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      return;
    end
    got_rdata = rsp_rdata;
    got_err = rsp_err;
    repeat (stall) @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    hs_cyc = cyc;
    $display("rsp  latency=%0d err=%0d rdata=0x%0h handshake at cycle %0d",
             lat, got_err, got_rdata, hs_cyc);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 64'(req_ready), 64'd1);
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 64'd0);
    chk({tag, "_rsp_err"}, 64'(rsp_err), 64'd0);
    chk({tag, "_cs"}, 64'(cs), 64'd0);
    chk({tag, "_we"}, 64'(we), 64'd0);
    chk({tag, "_re"}, 64'(re), 64'd0);
    chk({tag, "_waddr"}, 64'(write_address), 64'd0);
    chk({tag, "_raddr"}, 64'(read_address), 64'd0);
    chk({tag, "_wdata"}, write_data, 64'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    nrst = 1'b1;
    @(posedge clk);
    #1;

    // Store WORD 0xDEADBEEF to 0x104 -> upper half of the line
    issue(1'b1, 2'd2, 1'b0, 32'h104, 64'hDEAD_BEEF, 1'b0);
    chk("model_st_wd", e_wd, 64'hDEAD_BEEF_0000_0000);
    chk("st_word_cs", 64'(iss_cs), 64'd1);
    chk("st_word_we", 64'(iss_we), 64'(WORD_OP));
    chk("st_word_wa", 64'(iss_wa), 64'h104);
    chk("st_word_wd", iss_wd, 64'hDEAD_BEEF_0000_0000);
    wait_rsp(0);
    chk("st_word_lat", 64'(lat), 64'd2);
    chk("st_word_err", 64'(got_err), 64'd0);

    issue(1'b1, 2'd0, 1'b0, 32'h107, 64'h80, 1'b0);
    chk("st_byte_wd", iss_wd, 64'h8000_0000_0000_0000);
    wait_rsp(0);
    chk("st_byte_lat", 64'(lat), 64'd2);

    // Signed / unsigned BYTE loads of 0x80
    issue(1'b0, 2'd0, 1'b1, 32'h107, 64'h0, 1'b0);
    chk("model_ld_s8", e_rsp_rdata, 64'hFFFF_FFFF_FFFF_FF80);
    chk("ld_s8_re", 64'(iss_re), 64'(BYTE_OP));
    chk("ld_s8_ra", 64'(iss_ra), 64'h107);
    wait_rsp(0);
    chk("ld_s8_lat", 64'(lat), 64'd3);
    chk("ld_s8_data", got_rdata, 64'hFFFF_FFFF_FFFF_FF80);

    issue(1'b0, 2'd0, 1'b0, 32'h107, 64'h0, 1'b0);
    wait_rsp(0);
    chk("ld_u8_data", got_rdata, 64'h80);

    issue(1'b0, 2'd2, 1'b1, 32'h104, 64'h0, 1'b0);
    wait_rsp(0);
    chk("ld_s32_data", got_rdata, 64'hFFFF_FFFF_80AD_BEEF);

    // Illegal requests: misaligned HALF, misaligned DWORD
    issue(1'b0, 2'd1, 1'b0, 32'h103, 64'h0, 1'b0);
    chk("mis_half_cs", 64'(iss_cs), 64'd0);
    wait_rsp(0);
    chk("mis_half_lat", 64'(lat), 64'd1);
    chk("mis_half_err", 64'(got_err), 64'd1);
    chk("mis_half_data", got_rdata, 64'd0);

    issue(1'b1, 2'd3, 1'b0, 32'h4, 64'h1111, 1'b0);
    wait_rsp(0);
    chk("mis_dword_err", 64'(got_err), 64'd1);

    // Backpressure with a second request held on the request port
    issue(1'b0, 2'd1, 1'b1, 32'h106, 64'h0, 1'b0);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd1; req_signed = 1'b0;
    req_addr = 32'h10; req_wdata = 64'h1234;
    wait_rsp(5);
    chk("bp_lat", 64'(lat), 64'd3);
    chk("bp_data", got_rdata, 64'hFFFF_FFFF_FFFF_80AD);
    issue(1'b1, 2'd1, 1'b0, 32'h10, 64'h1234, 1'b0);
    chk("bp_accept_gap", 64'(acc_cyc - hs_cyc), 64'd1);
    chk("bp_st_wd", iss_wd, 64'h1234);
    wait_rsp(0);

    // Back-to-back DWORD stores
    issue(1'b1, 2'd3, 1'b0, 32'h0, 64'h0123_4567_89AB_CDEF, 1'b0);
    prev_acc = acc_cyc;
    wait_rsp(0);
    issue(1'b1, 2'd3, 1'b0, 32'h8, 64'hFEDC_BA98_7654_3210, 1'b0);
    chk("b2b_gap", 64'(acc_cyc - prev_acc), 64'd3);
    wait_rsp(0);

    issue(1'b0, 2'd3, 1'b1, 32'h8, 64'h0, 1'b0);
    wait_rsp(0);
    chk("ld_dword", got_rdata, 64'hFEDC_BA98_7654_3210);
    issue(1'b0, 2'd1, 1'b0, 32'h10, 64'h0, 1'b0);
    wait_rsp(0);
    chk("ld_half", got_rdata, 64'h1234);
    issue(1'b0, 2'd2, 1'b0, 32'h4, 64'h0, 1'b0);
    wait_rsp(0);
    chk("ld_word_hi", got_rdata, 64'h0123_4567);
    issue(1'b0, 2'd2, 1'b1, 32'h0, 64'h0, 1'b0);
    wait_rsp(0);
    chk("ld_word_lo_s", got_rdata, 64'hFFFF_FFFF_89AB_CDEF);

    // Reset while the load sits in CAPTURE
    issue(1'b0, 2'd2, 1'b0, 32'h104, 64'h0, 1'b0);
    @(posedge clk);
    #1;
    nrst = 1'b0;
    #1;
    check_reset_outputs("midrst");
    repeat (2) @(posedge clk);
    #1;
    nrst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("post_rst_req_ready", 64'(req_ready), 64'd1);
    end
    @(posedge clk);
    #1;

    issue(1'b0, 2'd2, 1'b0, 32'h104, 64'h0, 1'b0);
    wait_rsp(0);
    chk("post_rst_lat", 64'(lat), 64'd3);
    chk("post_rst_data", got_rdata, 64'h80AD_BEEF);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
